// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for display blocks.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to seven-segment decoder.
// Non-decimal codes show a dash so bad data is visible on the display.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: the default arm covers every code, so no latch is inferred.
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Four-digit multiplexed common-anode driver with per-frame snapshot,
// leading-zero blanking and an all-dash error pattern.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd,
    input  logic        blank_lz,
    input  logic        err,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic             tick;
    logic             frame_wrap;

    logic [15:0]      snap_bcd;
    logic             snap_blz;
    logic             snap_err;

    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic             blank;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;

    assign tick       = (div_cnt == DIV_LAST);
    assign frame_wrap = tick && (idx == 2'(DIGITS - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            idx      <= '0;
            snap_bcd <= '0;
            snap_blz <= 1'b0;
            snap_err <= 1'b0;
            an       <= 4'b1111;
            seg      <= SEG_BLANK;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            // Capturing only at the frame boundary keeps a frame from mixing two values.
            if (frame_wrap) begin
                snap_bcd <= bcd;
                snap_blz <= blank_lz;
                snap_err <= err;
            end
            an  <= an_next;
            seg <= seg_next;
        end
    end

    assign nibble = 4'(snap_bcd >> {idx, 2'b00});

    bcd_to_seg7 u_dec (
        .digit (nibble),
        .seg   (glyph)
    );

    // A digit is a leading zero when it and every more-significant nibble are zero.
    assign blank = snap_blz && (idx != 2'd0) && ((snap_bcd >> {idx, 2'b00}) == 16'd0);

    always_comb begin
        seg_next = glyph;
        if (snap_err) begin
            seg_next = SEG_DASH;
        end else if (blank) begin
            seg_next = SEG_BLANK;
        end
        an_next = ~(4'b0001 << idx);
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan: a frame-level model checked every
// cycle, plus hand-computed expectations at chosen digit slots.
module tb_bcd_seg7_scan;

    localparam int RD    = 4;
    localparam int FRAME = 4 * RD;

    logic        clk;
    logic        rst;
    logic [15:0] bcd;
    logic        blank_lz;
    logic        err;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int errors = 0;
    int checks = 0;

    bcd_seg7_scan #(.REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd      (bcd),
        .blank_lz (blank_lz),
        .err      (err),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph_of(input int n);
        case (n)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] b, input logic er,
                                             input logic bz, input int k);
        int upper;
        upper = int'(b) >> (4 * k);
        if (er) return 7'b0111111;
        if (bz && k > 0 && upper == 0) return 7'b1111111;
        return glyph_of(upper % 16);
    endfunction

    function automatic logic [3:0] model_an(input int k);
        logic [3:0] onehot;
        onehot = 4'b0001 << k;
        return ~onehot;
    endfunction

    // Frame-level model: edge count since reset release gives the digit slot;
    // the displayed frame uses the inputs seen at the previous frame boundary.
    bit          armed = 0;
    int          e = 0;
    logic [15:0] m_bcd;
    logic        m_err;
    logic        m_blz;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;

    always @(posedge clk) begin
        if (rst) begin
            armed   <= 1;
            e       <= 0;
            m_bcd   <= '0;
            m_err   <= 1'b0;
            m_blz   <= 1'b0;
            exp_an  <= 4'b1111;
            exp_seg <= 7'b1111111;
        end else if (armed) begin
            e       <= e + 1;
            exp_an  <= model_an((e / RD) % 4);
            exp_seg <= model_seg(m_bcd, m_err, m_blz, (e / RD) % 4);
            if ((e + 1) % FRAME == 0) begin
                m_bcd <= bcd;
                m_err <= err;
                m_blz <= blank_lz;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_an", 32'(an), 32'(exp_an));
            check("model_seg", 32'(seg), 32'(exp_seg));
            check("model_dp", 32'(dp), 32'd1);
        end
    end

    task automatic do_reset(input logic [15:0] b, input logic bz, input logic er);
        @(negedge clk);
        rst      = 1'b1;
        bcd      = b;
        blank_lz = bz;
        err      = er;
        @(negedge clk);
        check("reset_an", 32'(an), 32'h0000000f);
        check("reset_seg", 32'(seg), 32'h0000007f);
        rst = 1'b0;
    endtask

    task automatic to_edge(input int n);
        int guard;
        guard = 0;
        while (e < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (e != n) begin
            errors++;
            checks++;
            $display("FAIL to_edge: reached edge %0d expected %0d", e, n);
        end
    endtask

    task automatic lit(input string name, input int n, input logic [3:0] a, input logic [6:0] s);
        to_edge(n);
        check({name, "_an"}, 32'(an), 32'(a));
        check({name, "_seg"}, 32'(seg), 32'(s));
    endtask

    initial begin
        rst      = 1'b1;
        bcd      = '0;
        blank_lz = 1'b0;
        err      = 1'b0;

        // Scan sequence after reset with a zero value
        do_reset(16'h0000, 1'b0, 1'b0);
        check("first_cycle_an", 32'(an), 32'h0000000f);
        lit("scan_d0", 1, 4'b1110, 7'b1000000);
        lit("scan_d0_hold", 4, 4'b1110, 7'b1000000);
        lit("scan_d1", 5, 4'b1101, 7'b1000000);
        lit("scan_d2", 9, 4'b1011, 7'b1000000);
        lit("scan_d3", 13, 4'b0111, 7'b1000000);
        lit("scan_wrap", 17, 4'b1110, 7'b1000000);

        // Plain value, no blanking
        do_reset(16'h1234, 1'b0, 1'b0);
        lit("v1234_pre", 13, 4'b0111, 7'b1000000);
        lit("v1234_d0", 17, 4'b1110, 7'b0011001);
        lit("v1234_d1", 21, 4'b1101, 7'b0110000);
        lit("v1234_d2", 25, 4'b1011, 7'b0100100);
        lit("v1234_d3", 29, 4'b0111, 7'b1111001);

        // Leading-zero blanking
        do_reset(16'h0042, 1'b1, 1'b0);
        lit("lz42_d0", 17, 4'b1110, 7'b0100100);
        lit("lz42_d1", 21, 4'b1101, 7'b0011001);
        lit("lz42_d2", 25, 4'b1011, 7'b1111111);
        lit("lz42_d3", 29, 4'b0111, 7'b1111111);
        do_reset(16'h0000, 1'b1, 1'b0);
        lit("lz0_d0", 17, 4'b1110, 7'b1000000);
        lit("lz0_d1", 21, 4'b1101, 7'b1111111);
        lit("lz0_d3", 29, 4'b0111, 7'b1111111);

        // Input change mid-frame must not tear the frame
        do_reset(16'h1111, 1'b0, 1'b0);
        to_edge(22);
        bcd = 16'h2222;
        lit("tear_d2", 25, 4'b1011, 7'b1111001);
        lit("tear_d3", 29, 4'b0111, 7'b1111001);
        lit("tear_next_d0", 33, 4'b1110, 7'b0100100);
        lit("tear_next_d1", 37, 4'b1101, 7'b0100100);

        // Error pattern overrides digits and blanking
        do_reset(16'h0007, 1'b1, 1'b1);
        lit("err_d0", 17, 4'b1110, 7'b0111111);
        lit("err_d1", 21, 4'b1101, 7'b0111111);
        lit("err_d2", 25, 4'b1011, 7'b0111111);
        lit("err_d3", 29, 4'b0111, 7'b0111111);
        do_reset(16'h000a, 1'b0, 1'b0);
        lit("hexa_d0", 17, 4'b1110, 7'b0111111);
        lit("hexa_d1", 21, 4'b1101, 7'b1000000);

        // Reset mid-frame while digit 2 is showing
        do_reset(16'h1234, 1'b0, 1'b0);
        lit("mid_d2", 26, 4'b1011, 7'b0100100);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", 32'(an), 32'h0000000f);
        check("midrst_seg", 32'(seg), 32'h0000007f);
        rst = 1'b0;
        lit("midrst_d0", 1, 4'b1110, 7'b1000000);
        lit("midrst_d1", 5, 4'b1101, 7'b1000000);
        lit("midrst_cap", 17, 4'b1110, 7'b0011001);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
